// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment driver: per-frame shadow latch, guarded anode scan, optional leading-zero blanking.
// Latency: seg/dp/an/frame_done are registered, one cycle behind the scan state (cnt, idx, shadow).
// Backpressure: none; inputs are sampled once per frame and otherwise ignored.
// Optional build macro HEX_DECODE_EN: when defined, nibbles 10..15 show A,b,C,d,E,F instead of staying dark.
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lz_en,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [6:0]    SEG_DARK = 7'b1111111;

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [3:0]            sh_nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] sh_dp;
  logic [NUM_DIGITS-1:0] sh_blank;
  logic                  sh_lz;

  logic [NUM_DIGITS-1:0] signif;
  logic                  sig_acc;
  logic [3:0]            cur_nib;
  logic                  in_guard;
  logic                  suppress;
  logic [6:0]            seg_nxt;
  logic                  dp_nxt;
  logic [NUM_DIGITS-1:0] an_nxt;

  // Segment patterns, active low, bit 6 = a ... bit 0 = g.
  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
`ifdef HEX_DECODE_EN
      4'd10:   s = 7'b0001000;
      4'd11:   s = 7'b1100000;
      4'd12:   s = 7'b0110001;
      4'd13:   s = 7'b1000010;
      4'd14:   s = 7'b0110000;
      4'd15:   s = 7'b0111000;
`endif
      default: s = SEG_DARK;
    endcase
    return s;
  endfunction

  // signif[i] is set when digit i or any digit above it is nonzero; digits without it are leading zeros.
  always_comb begin
    signif  = '0;
    sig_acc = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      sig_acc   = sig_acc | (sh_nib[i] != 4'd0);
      signif[i] = sig_acc;
    end
  end

  // Next output values from the current scan state; blanking beats suppression beats decode.
  always_comb begin
    cur_nib  = sh_nib[idx];
    in_guard = (int'(cnt) < GUARD);
    suppress = sh_lz && (idx != '0) && !signif[idx];
    seg_nxt  = (sh_blank[idx] || suppress) ? SEG_DARK : decode(cur_nib);
    dp_nxt   = sh_blank[idx] ? 1'b1 : ~sh_dp[idx];
    an_nxt   = in_guard ? '1 : ~(NUM_DIGITS'(1) << idx);
  end

  // Slot divider, digit index, frame-boundary shadow latch and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) sh_nib[i] <= 4'd0;
      sh_dp      <= '0;
      sh_blank   <= '0;
      sh_lz      <= 1'b0;
      seg        <= SEG_DARK;
      dp         <= 1'b1;
      an         <= '1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        if (idx == IDX_LAST) begin
          idx        <= '0;
          for (int i = 0; i < NUM_DIGITS; i++) sh_nib[i] <= digits[4*i +: 4];
          sh_dp      <= dp_in;
          sh_blank   <= blank_in;
          sh_lz      <= lz_en;
          frame_done <= 1'b1;
        end else begin
          idx <= idx + 1'b1;
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
      seg <= seg_nxt;
      dp  <= dp_nxt;
      an  <= an_nxt;
    end
  end

endmodule
